// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: FSM encoding and
// the word returned for misaligned fetches.
package imem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam int          WCNT_W   = 4;

endpackage

// File: rtl/imem_array.sv
// Word-addressed instruction store: synchronous write port plus a read port
// whose data register is loaded only when i_re is asserted.
module imem_array #(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [31:0]           i_wdata,
  input  logic                  i_re,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [31:0]           o_rdata
);

  logic [31:0] r_mem [2**DEPTH_LOG2];
  logic [31:0] r_rdata;

  // Contents survive reset so a loaded program persists.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Same-edge write to the read index yields the old word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_responder.sv
// Single-outstanding instruction fetch responder with a fixed WAIT_CYCLES
// latency; flush abandons the fetch, response holds until accepted.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_LOG2  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [31:0]           req_addr,
  output logic                  req_ready,
  input  logic                  flush,
  input  logic                  rsp_accept,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_instr,
  output logic [31:0]           rsp_addr,
  output logic                  rsp_misaligned,
  input  logic                  prog_we,
  input  logic [DEPTH_LOG2-1:0] prog_addr,
  input  logic [31:0]           prog_data
);

  localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'(WAIT_CYCLES);
  localparam bit                NO_WAIT   = (WAIT_CYCLES == 0);

  imem_state_e           r_state, w_next;
  logic [WCNT_W-1:0]     r_wait_cnt;
  logic [31:0]           r_addr;
  logic [31:0]           w_rdata;
  logic                  w_accept, w_wait_done, w_rd_en;
  logic [DEPTH_LOG2-1:0] w_rd_idx;

  assign w_accept    = (r_state == IDLE) && req_valid && !flush;
  assign w_wait_done = (r_state == WAIT) && !flush && (r_wait_cnt <= WCNT_W'(1));
  assign w_rd_en     = (w_accept && NO_WAIT) || w_wait_done;
  // Zero-wait fetches read on the accepting edge, before r_addr is loaded.
  assign w_rd_idx    = (r_state == IDLE) ? req_addr[DEPTH_LOG2+1:2]
                                         : r_addr[DEPTH_LOG2+1:2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = NO_WAIT ? RESP : WAIT;
      WAIT:    if (flush) w_next = IDLE;
               else if (w_wait_done) w_next = RESP;
      RESP:    if (flush || rsp_accept) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (r_state == IDLE);
    rsp_valid = (r_state == RESP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt <= '0;
      r_addr     <= '0;
    end else if (w_accept) begin
      r_wait_cnt <= WAIT_INIT;
      r_addr     <= req_addr;
    end else if (r_state == WAIT) begin
      r_wait_cnt <= flush ? '0 : r_wait_cnt - WCNT_W'(1);
    end
  end

  imem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk     (clk),
    .reset   (reset),
    .i_we    (prog_we),
    .i_waddr (prog_addr),
    .i_wdata (prog_data),
    .i_re    (w_rd_en),
    .i_raddr (w_rd_idx),
    .o_rdata (w_rdata)
  );

  // r_addr only changes on acceptance, so these hold steady through RESP.
  assign rsp_addr       = r_addr;
  assign rsp_misaligned = (r_addr[1:0] != 2'b00);
  assign rsp_instr      = rsp_misaligned ? NOP_WORD : w_rdata;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: a WAIT_CYCLES=2 instance for most cases
// and a WAIT_CYCLES=0 instance for the zero-latency hold case.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, flush, rsp_accept;
  logic [31:0] req_addr;
  logic        req_ready, rsp_valid, rsp_misaligned;
  logic [31:0] rsp_instr, rsp_addr;
  logic        prog_we;
  logic [5:0]  prog_addr;
  logic [31:0] prog_data;

  logic        req1_valid, flush1, rsp1_accept;
  logic [31:0] req1_addr;
  logic        req1_ready, rsp1_valid, rsp1_misaligned;
  logic [31:0] rsp1_instr, rsp1_addr;

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  imem_responder #(.WAIT_CYCLES(2), .DEPTH_LOG2(6)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .flush(flush), .rsp_accept(rsp_accept),
    .rsp_valid(rsp_valid), .rsp_instr(rsp_instr), .rsp_addr(rsp_addr),
    .rsp_misaligned(rsp_misaligned),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
  );

  imem_responder #(.WAIT_CYCLES(0), .DEPTH_LOG2(6)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req1_valid), .req_addr(req1_addr), .req_ready(req1_ready),
    .flush(flush1), .rsp_accept(rsp1_accept),
    .rsp_valid(rsp1_valid), .rsp_instr(rsp1_instr), .rsp_addr(rsp1_addr),
    .rsp_misaligned(rsp1_misaligned),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [5:0] idx, input logic [31:0] data);
    prog_we = 1'b1; prog_addr = idx; prog_data = data;
    tick();
    prog_we = 1'b0;
  endtask

  // Presents one request for a single edge; returns just after the accepting edge.
  task automatic issue(input logic [31:0] addr);
    req_addr = addr; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0; rsp_accept = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    req1_valid = 1'b0; req1_addr = '0; flush1 = 1'b0; rsp1_accept = 1'b0;

    #2;
    chk("rst valid", rsp_valid, 0);
    chk("rst instr", rsp_instr, 0);
    chk("rst addr",  rsp_addr, 0);
    chk("rst mis",   rsp_misaligned, 0);
    chk("rst ready", req_ready, 1);
    tick(); tick();
    reset = 1'b1;
    tick();

    prog(6'd5, 32'h8C22_0004);
    prog(6'd1, 32'h1111_1111);
    prog(6'd0, 32'hAAAA_0000);

    // Aligned fetch, accept held high: response in the third cycle.
    rsp_accept = 1'b1;
    issue(32'h14);
    chk("t1 ready0", req_ready, 0);
    chk("t1 v_e0",   rsp_valid, 0);
    tick();
    chk("t1 v_e1",   rsp_valid, 0);
    tick();
    chk("t1 v_e2",   rsp_valid, 1);
    chk("t1 instr",  rsp_instr, 32'h8C22_0004);
    chk("t1 addr",   rsp_addr, 32'h14);
    chk("t1 mis",    rsp_misaligned, 0);
    tick();
    chk("t1 exit v", rsp_valid, 0);
    chk("t1 exit r", req_ready, 1);
    rsp_accept = 1'b0;

    // Misaligned fetch returns a nop with the same latency.
    issue(32'h16);
    tick();
    chk("mis v_e1", rsp_valid, 0);
    tick();
    chk("mis valid", rsp_valid, 1);
    chk("mis instr", rsp_instr, 32'h0);
    chk("mis flag",  rsp_misaligned, 1);
    chk("mis addr",  rsp_addr, 32'h16);
    rsp_accept = 1'b1;
    tick();
    rsp_accept = 1'b0;
    chk("mis exit", rsp_valid, 0);

    // Flush one cycle after acceptance abandons the fetch.
    issue(32'h14);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl ready", req_ready, 1);
    chk("fl valid", rsp_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl novalid", rsp_valid, 0);
    end

    // Aliased address; write to the read index on the read edge and in RESP.
    issue(32'h104);
    tick();
    prog_we = 1'b1; prog_addr = 6'd1; prog_data = 32'h2222_2222;
    tick();
    chk("al valid", rsp_valid, 1);
    chk("al rbw",   rsp_instr, 32'h1111_1111);
    chk("al addr",  rsp_addr, 32'h104);
    prog_data = 32'h3333_3333;
    tick();
    prog_we = 1'b0;
    chk("al hold v", rsp_valid, 1);
    chk("al hold",   rsp_instr, 32'h1111_1111);
    rsp_accept = 1'b1;
    tick();
    rsp_accept = 1'b0;
    issue(32'h4);
    tick(); tick();
    chk("al new", rsp_instr, 32'h3333_3333);
    rsp_accept = 1'b1;
    tick();
    rsp_accept = 1'b0;

    // Zero-wait instance: response next cycle, held while not accepted.
    req1_addr = 32'h0; req1_valid = 1'b1;
    tick();
    req1_valid = 1'b0;
    chk("z valid", rsp1_valid, 1);
    chk("z instr", rsp1_instr, 32'hAAAA_0000);
    chk("z addr",  rsp1_addr, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("z hold v", rsp1_valid, 1);
      chk("z hold i", rsp1_instr, 32'hAAAA_0000);
      chk("z hold a", rsp1_addr, 32'h0);
    end
    rsp1_accept = 1'b1;
    tick();
    rsp1_accept = 1'b0;
    chk("z exit", rsp1_valid, 0);

    // Reset asserted while in WAIT clears outputs without a clock edge.
    issue(32'h14);
    reset = 1'b0;
    #1;
    chk("ar valid", rsp_valid, 0);
    chk("ar instr", rsp_instr, 0);
    chk("ar addr",  rsp_addr, 0);
    chk("ar mis",   rsp_misaligned, 0);
    chk("ar ready", req_ready, 1);
    tick(); tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ar norsp", rsp_valid, 0);
    end

    // Memory contents persist across reset.
    issue(32'h14);
    tick(); tick();
    chk("keep valid", rsp_valid, 1);
    chk("keep instr", rsp_instr, 32'h8C22_0004);
    rsp_accept = 1'b1;
    tick();
    rsp_accept = 1'b0;

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
